degamma: RTL and testbench
==========================

DEGAMMA -- requirements
Module: degamma

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: src_valid  input  1  upstream pixel valid.
REQ-004 SHALL have port: src_ready  output  1  block accepts src_data this cycle.
REQ-005 SHALL have port: src_data  input  8  gamma-encoded pixel (gamma 0.55 curve).
REQ-006 SHALL have port: dst_valid  output  1  dst_data holds a result.
REQ-007 SHALL have port: dst_ready  input  1  downstream accepts dst_data this cycle.
REQ-008 SHALL have port: dst_data  output  8  linearized pixel.
REQ-009 SHALL have port: rebuild  input  1  single-cycle request to regenerate the inverse table.
REQ-010 SHALL have port: busy  output  1  high while the inverse table is being built or a rebuild is pending.

Function
REQ-011 Inverse table SHALL satisfy inv[y] = smallest x in 0..255 with FWD[x] >= y, where FWD is the 256-entry gamma-0.55 forward curve (FWD[0]=1, FWD[1]=12, FWD[255]=255, monotone non-decreasing).
REQ-012 FSM states: BUILD, RUN, DRAIN; reset state BUILD.
REQ-013 BUILD: counters x, y (8 bits each) start at 0; each cycle, if FWD[x] >= y then write inv[y]=x and increment y, else increment x; writing y=255 SHALL transition to RUN.
REQ-014 BUILD SHALL last exactly 511 cycles (256 writes + 255 x increments); x SHALL never wrap.
REQ-015 busy SHALL be 1 in BUILD and DRAIN, 0 in RUN.
REQ-016 src_ready SHALL equal (state==RUN) && (!dst_valid || dst_ready) && !rebuild.
REQ-017 Transfer on src side when src_valid && src_ready; dst_data <= inv[src_data], dst_valid <= 1 on the next rising edge (latency 1 cycle).
REQ-018 dst_valid SHALL clear on a cycle with dst_valid && dst_ready and no new src transfer; simultaneous src transfer and dst transfer SHALL replace data with dst_valid remaining 1 (full throughput, one pixel per cycle).
REQ-019 dst_data/dst_valid SHALL hold stable while dst_valid && !dst_ready.
REQ-020 rebuild in RUN SHALL move to DRAIN; DRAIN SHALL move to BUILD (counters cleared) in the first cycle with dst_valid==0; rebuild in BUILD or DRAIN SHALL be ignored.
REQ-021 Table reads SHALL be asynchronous; table writes SHALL occur only in BUILD.

Reset
REQ-022 On rst_n low: state=BUILD, x=y=0, dst_valid=0, dst_data=0, src_ready=0, busy=1.
REQ-023 Reset asserted mid-BUILD or mid-RUN SHALL abort the operation; the table SHALL be fully rebuilt after release, with no output pixel issued before BUILD completes.
REQ-024 Table storage SHALL NOT require reset.

Structure
REQ-025 Shared package gamma_pkg SHALL hold: FWD table constant (256x8), pixel width 8, FSM state type {BUILD, RUN, DRAIN}, BUILD_CYCLES=511.
REQ-026 One sub-module degamma_inv_ram: 256x8 register array, one synchronous write port, one asynchronous read port.
REQ-027 Top module SHALL contain FSM, build counters, and output register only.

Verification
REQ-028 Release reset, hold src_valid=1 -> busy=1, src_ready=0 for exactly 511 cycles, then src_ready=1, busy=0.
REQ-029 After build, dst_ready=1, stream src_data 0,1,12,13,128,255 -> dst_data 0,0,1,2,73,255, each one cycle after acceptance, back-to-back.
REQ-030 Exhaustive: src_data 0..255 -> dst_data equals inv[] per REQ-011 from the package FWD model; output non-decreasing.
REQ-031 Backpressure: dst_ready=0 for 5 cycles with dst_valid=1, dst_data=73 -> dst_data held at 73, src_ready=0; dst_ready=1 -> transfer, then next pixel accepted.
REQ-032 rebuild pulse while dst_valid=1, dst_ready=0 -> src_ready=0, busy=1, state DRAIN until dst accepted, then 511-cycle BUILD, then results identical to REQ-029.
REQ-033 rst_n pulse at BUILD cycle 200 -> no dst_valid, src_ready rises exactly 511 cycles after release.

Source files
------------

// File: rtl/gamma_pkg.sv
// Shared definitions for the degamma block.
// Holds the pixel width, FSM state type, build length and the 256-entry
// gamma-0.55 forward curve FWD[x] = max(1, round(255 * (x/255)^0.55)).
package gamma_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned TBL_DEPTH    = 256;
    localparam int unsigned BUILD_CYCLES = 511;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {BUILD, RUN, DRAIN} state_t;

    localparam int unsigned BIG_W = 200;

    function automatic logic [BIG_W-1:0] big_pow(input logic [BIG_W-1:0] b, input int unsigned n);
        logic [BIG_W-1:0] r;
        r = BIG_W'(1);
        for (int unsigned i = 0; i < n; i++) begin
            r = r * b;
        end
        return r;
    endfunction

    // Exact integer evaluation of the curve: 255*(x/255)^(11/20) >= y - 0.5
    // is equivalent to (2y-1)^20 <= x^11 * 255^9 * 2^20, which avoids reals.
    function automatic logic [TBL_DEPTH-1:0][PIX_W-1:0] gen_fwd();
        logic [TBL_DEPTH-1:0][PIX_W-1:0] tbl;
        logic [BIG_W-1:0]                scale;
        logic [BIG_W-1:0]                rhs;
        int unsigned                     y;
        logic                            done;
        scale = big_pow(BIG_W'(255), 9) * big_pow(BIG_W'(2), 20);
        y     = 1;
        for (int unsigned x = 0; x < TBL_DEPTH; x++) begin
            rhs  = scale * big_pow(BIG_W'(x), 11);
            done = 1'b0;
            while ((y < 255) && !done) begin
                if (big_pow(BIG_W'(2 * y + 1), 20) <= rhs) begin
                    y = y + 1;
                end else begin
                    done = 1'b1;
                end
            end
            tbl[x] = PIX_W'(y);
        end
        return tbl;
    endfunction

    localparam logic [TBL_DEPTH-1:0][PIX_W-1:0] FWD = gen_fwd();

endpackage

// File: rtl/degamma_inv_ram.sv
// Inverse gamma table storage: 256 x 8 register array.
// Ports: clk (write clock), we_i/waddr_i/wdata_i (synchronous write port),
//        raddr_i/rdata_o (asynchronous read port). No reset on the storage.
module degamma_inv_ram
    import gamma_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [PIX_W-1:0] waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic [PIX_W-1:0] raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    pix_t mem [TBL_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/degamma.sv
// Pixel linearizer: maps gamma-0.55 encoded pixels to linear values through
// an inverse table that the block builds itself from the forward curve.
// Ports: clk, rst_n (async, active-low);
//        src_valid/src_ready/src_data  upstream pixel handshake;
//        dst_valid/dst_ready/dst_data  downstream result handshake (1-cycle latency);
//        rebuild  request to regenerate the table; busy  high unless in RUN.
module degamma
    import gamma_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [PIX_W-1:0] src_data,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [PIX_W-1:0] dst_data,
    input  logic             rebuild,
    output logic             busy
);

    state_t state_q;
    pix_t   x_q;
    pix_t   y_q;
    logic   dst_valid_q;
    pix_t   dst_data_q;

    logic   hit;
    logic   tbl_we;
    logic   src_fire;
    pix_t   tbl_rdata;

    // FWD is monotone with FWD[255]=255, so x stops at 255 before y reaches
    // 255 and never wraps.
    assign hit       = (FWD[x_q] >= y_q);
    assign tbl_we    = (state_q == BUILD) && hit;
    assign src_ready = (state_q == RUN) && (!dst_valid_q || dst_ready) && !rebuild;
    assign src_fire  = src_valid && src_ready;
    assign busy      = (state_q != RUN);
    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;

    degamma_inv_ram u_inv_ram (
        .clk     (clk),
        .we_i    (tbl_we),
        .waddr_i (y_q),
        .wdata_i (x_q),
        .raddr_i (src_data),
        .rdata_o (tbl_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUILD;
            x_q         <= '0;
            y_q         <= '0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
        end else begin
            case (state_q)
                BUILD: begin
                    if (hit) begin
                        y_q <= y_q + 8'd1;
                        if (y_q == 8'hFF) begin
                            state_q <= RUN;
                        end
                    end else begin
                        x_q <= x_q + 8'd1;
                    end
                end
                RUN: begin
                    if (rebuild) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait for the last result to leave before overwriting the table.
                    if (!dst_valid_q) begin
                        state_q <= BUILD;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                default: begin
                    state_q <= BUILD;
                end
            endcase

            if (src_fire) begin
                dst_valid_q <= 1'b1;
                dst_data_q  <= tbl_rdata;
            end else if (dst_ready) begin
                dst_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_degamma.sv
// Self-checking bench for degamma: table-driven vectors, a scoreboard of
// expected results, and hand-written build/backpressure/rebuild/reset sequences.
module tb_degamma;
    import gamma_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic src_valid;
    logic src_ready;
    logic [7:0] src_data;
    logic dst_valid;
    logic dst_ready;
    logic [7:0] dst_data;
    logic rebuild;
    logic busy;

    always #5 clk = ~clk;

    degamma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst_data  (dst_data),
        .rebuild   (rebuild),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] model_inv [256];
    logic [7:0] sb [$];
    logic [7:0] cur_exp;
    logic       mono_on;
    logic [7:0] last_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop before push so each result matches the pixel accepted earlier.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dst_valid && dst_ready) begin
                chk("output_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("dst_data", int'(dst_data), int'(sb.pop_front()));
                end
                if (mono_on) begin
                    chk("monotone", int'(dst_data >= last_out), 1);
                    last_out = dst_data;
                end
            end
            if (src_valid && src_ready) begin
                sb.push_back(cur_exp);
            end
        end
    end

    // Counts rising edges until src_ready appears; optionally pulses rebuild
    // on edge rb_at to confirm it is ignored.
    task automatic wait_build(input int rb_at, input bit chk_dv, output int n);
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (src_ready) break;
            chk("busy_while_building", int'(busy), 1);
            if (chk_dv) chk("no_output_during_build", int'(dst_valid), 0);
            step();
            rebuild = (n == rb_at);
            n++;
        end
        rebuild = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 6; i++) begin
            src_valid = 1'b1;
            src_data  = vecs[i].din;
            cur_exp   = vecs[i].dout;
            @(negedge clk);
            chk("table_accept", int'(src_ready), 1);
            if (i > 0) chk("table_back_to_back", int'(dst_valid), 1);
            step();
        end
        src_valid = 1'b0;
        step();
        step();
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    int n;

    initial begin
        vecs[0] = '{din: 8'd0,   dout: 8'd0};
        vecs[1] = '{din: 8'd1,   dout: 8'd0};
        vecs[2] = '{din: 8'd12,  dout: 8'd1};
        vecs[3] = '{din: 8'd13,  dout: 8'd2};
        vecs[4] = '{din: 8'd128, dout: 8'd73};
        vecs[5] = '{din: 8'd255, dout: 8'd255};

        // Reference inverse: smallest x with FWD[x] >= y.
        for (int y = 0; y < 256; y++) begin
            model_inv[y] = 8'd255;
            for (int x = 255; x >= 0; x--) begin
                if (int'(FWD[x]) >= y) model_inv[y] = 8'(x);
            end
        end

        rst_n = 1'b0; src_valid = 1'b0; src_data = '0; dst_ready = 1'b1;
        rebuild = 1'b0; cur_exp = '0; mono_on = 1'b0; last_out = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 1);
        chk("reset_src_ready", int'(src_ready), 0);
        chk("reset_dst_valid", int'(dst_valid), 0);
        chk("reset_dst_data", int'(dst_data), 0);

        // Initial build with src_valid held high; a rebuild pulse mid-build is ignored.
        step();
        rst_n = 1'b1; src_valid = 1'b1; src_data = 8'd0; cur_exp = model_inv[0];
        wait_build(100, 1'b1, n);
        chk("build_cycles", n, 511);
        chk("run_busy", int'(busy), 0);
        step();
        run_table();

        // Exhaustive sweep, full throughput.
        mono_on = 1'b1; last_out = '0;
        for (int v = 0; v < 256; v++) begin
            src_valid = 1'b1; src_data = 8'(v); cur_exp = model_inv[v];
            @(negedge clk);
            chk("sweep_accept", int'(src_ready), 1);
            step();
        end
        src_valid = 1'b0;
        step(); step();
        mono_on = 1'b0;
        chk("sweep_drained", sb.size(), 0);

        // Backpressure: result held for 5 cycles, input stalled.
        dst_ready = 1'b0; src_valid = 1'b1; src_data = 8'd128; cur_exp = 8'd73;
        @(negedge clk);
        chk("bp_first_accept", int'(src_ready), 1);
        step();
        src_data = 8'd255; cur_exp = 8'd255;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(dst_valid), 1);
            chk("bp_hold_data", int'(dst_data), 73);
            chk("bp_stall", int'(src_ready), 0);
            step();
        end
        dst_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", int'(src_ready), 1);
        step();
        src_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", int'(dst_valid), 1);
        chk("bp_next_data", int'(dst_data), 255);
        step(); step();

        // Rebuild while the output is stalled: drain, then full rebuild.
        dst_ready = 1'b0; src_valid = 1'b1; src_data = 8'd128; cur_exp = 8'd73;
        @(negedge clk);
        chk("rb_accept", int'(src_ready), 1);
        step();
        src_data = 8'd13; cur_exp = model_inv[13]; rebuild = 1'b1;
        @(negedge clk);
        chk("rb_src_blocked", int'(src_ready), 0);
        step();
        rebuild = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_busy", int'(busy), 1);
            chk("drain_src_ready", int'(src_ready), 0);
            chk("drain_hold_valid", int'(dst_valid), 1);
            chk("drain_hold_data", int'(dst_data), 73);
            step();
        end
        dst_ready = 1'b1;
        wait_build(-1, 1'b0, n);
        // One edge retires the result, one leaves DRAIN, then 511 build edges.
        chk("rebuild_cycles", n, 513);
        step();
        run_table();

        // Reset mid-RUN with a result pending, then reset again at build cycle 200.
        dst_ready = 1'b0; src_valid = 1'b1; src_data = 8'd128; cur_exp = 8'd73;
        step();
        src_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("run_reset_dst_valid", int'(dst_valid), 0);
        chk("run_reset_busy", int'(busy), 1);
        step();
        rst_n = 1'b1; dst_ready = 1'b1; src_valid = 1'b1; src_data = 8'd128; cur_exp = 8'd73;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("pre_abort_no_output", int'(dst_valid), 0);
            chk("pre_abort_src_ready", int'(src_ready), 0);
            step();
        end
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        wait_build(150, 1'b1, n);
        chk("post_reset_build_cycles", n, 511);
        step();
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
